// File: rtl/uart_pkg.sv
// Shared UART definitions for the audio receive and transmit paths:
// frame constants, FSM state encoding and the default bit period.
package uart_pkg;

  localparam int DATA_BITS          = 8;
  localparam int STOP_BITS          = 1;
  // 12 MHz system clock / 230400 baud
  localparam int DEFAULT_BIT_CYCLES = 52;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  typedef enum logic {
    LO = 1'b0,
    HI = 1'b1
  } byte_sel_e;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: load restarts it at BIT_CYCLES-1, tick marks the
// final cycle of the bit (count reads 0).
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int BIT_CYCLES = DEFAULT_BIT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic tick
);

  localparam int W = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= W'(BIT_CYCLES - 1);
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign tick = (count == '0);

endmodule

// File: rtl/sample_uart_tx.sv
// Serializes 16-bit samples as two back-to-back 8N1 bytes, low byte first.
// cts gates only the acceptance of a new sample, never the byte pair in flight.
module sample_uart_tx
  import uart_pkg::*;
#(
  parameter int BITS       = 16,
  parameter int BIT_CYCLES = DEFAULT_BIT_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  input  logic [BITS-1:0]   s_data,
  output logic              s_ready,
  input  logic              cts,
  output logic              tx,
  output logic              busy,
  output logic [15:0]       bytes_sent,
  output uart_state_e       state_dbg
);

  uart_state_e     state;
  byte_sel_e       byte_sel;
  logic [BITS-1:0] word;
  logic [2:0]      bit_idx;
  logic [15:0]     byte_count;
  logic [7:0]      cur_byte;
  logic            accept;
  logic            tick;
  logic            load;
  logic            last_stop;

  // Handshake: a sample transfers on any cycle where s_valid && s_ready;
  // s_ready depends only on state and cts, never on s_valid.
  assign s_ready   = (state == IDLE) && cts;
  assign accept    = s_valid && s_ready;
  assign cur_byte  = (byte_sel == HI) ? word[15:8] : word[7:0];
  assign last_stop = (state == STOP) && (byte_sel == HI);
  assign load      = accept || (tick && (state != IDLE) && !last_stop);

  uart_bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      byte_sel   <= LO;
      word       <= '0;
      bit_idx    <= '0;
      byte_count <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            word     <= s_data;
            byte_sel <= LO;
            state    <= START;
            tx       <= 1'b0;
            busy     <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            state   <= DATA;
            bit_idx <= '0;
            tx      <= cur_byte[0];
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == 3'(DATA_BITS - 1)) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= cur_byte[bit_idx + 3'd1];
            end
          end
        end
        STOP: begin
          if (tick) begin
            byte_count <= byte_count + 16'd1;
            // The high byte follows with no idle gap and no cts check.
            if (byte_sel == LO) begin
              byte_sel <= HI;
              state    <= START;
              tx       <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bytes_sent = byte_count;
  assign state_dbg  = state;

endmodule

// File: tb/tb_sample_uart_tx.sv
// Directed bench for sample_uart_tx at BIT_CYCLES=4: reset, single and
// back-to-back samples, cts flow control, mid-frame reset, counter wrap.
module tb_sample_uart_tx;
  import uart_pkg::*;

  localparam int BC = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_ready;
  logic        cts;
  logic        tx;
  logic        busy;
  logic [15:0] bytes_sent;
  uart_state_e state_dbg;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int t1, t2;
  logic [15:0] exp_bytes;

  sample_uart_tx #(
    .BITS      (16),
    .BIT_CYCLES(BC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .cts       (cts),
    .tx        (tx),
    .busy      (busy),
    .bytes_sent(bytes_sent),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with a sample already offered; waits for the frame start.
  task automatic wait_start(input string tag, input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (busy) break;
    end
    check({tag, "_start_busy"}, 32'(busy), 32'd1);
  endtask

  // Entered on the negedge of the first start-bit cycle. bits[k] is the k-th
  // line bit of the 20-bit sample frame; base is bytes_sent before the sample.
  task automatic check_frame(input string tag, input logic [19:0] bits, input logic [15:0] base);
    for (int i = 0; i < 20 * BC; i++) begin
      if (i > 0) @(negedge clk);
      check($sformatf("%s_tx%0d", tag, i), 32'(tx), 32'(bits[i / BC]));
      if (i == 0 || i == 20 * BC - 1) check({tag, "_busy"}, 32'(busy), 32'd1);
      if (i == 0 || i == 10 * BC - 1) check({tag, "_cnt_lo"}, 32'(bytes_sent), 32'(base));
      if (i == 10 * BC || i == 20 * BC - 1)
        check({tag, "_cnt_hi"}, 32'(bytes_sent), 32'(16'(base + 16'd1)));
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    cts     = 1'b1;
    s_valid = 1'b0;
    s_data  = 16'h0000;
    exp_bytes = 16'd0;

    // Reset and idle
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_tx", 32'(tx), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_ready", 32'(s_ready), 32'd1);
    check("idle_cnt", 32'(bytes_sent), 32'd0);
    check("idle_state", 32'(state_dbg), 32'(IDLE));

    // Single sample 0xA55A, one-cycle valid
    s_valid = 1'b1;
    s_data  = 16'hA55A;
    @(negedge clk);
    s_valid = 1'b0;
    check("a55a_start_busy", 32'(busy), 32'd1);
    check_frame("a55a", 20'b1_10100101_0_1_01011010_0, exp_bytes);
    exp_bytes = exp_bytes + 16'd2;
    @(negedge clk);
    check("a55a_end_busy", 32'(busy), 32'd0);
    check("a55a_end_tx", 32'(tx), 32'd1);
    check("a55a_end_cnt", 32'(bytes_sent), 32'(exp_bytes));

    // Back-to-back 0x0001 then 0x8000 with s_valid held
    s_valid = 1'b1;
    s_data  = 16'h0001;
    wait_start("b2b0", 10);
    t1 = cyc;
    s_data = 16'h8000;
    check_frame("b2b0", 20'b1_00000000_0_1_00000001_0, exp_bytes);
    exp_bytes = exp_bytes + 16'd2;
    @(negedge clk);
    check("b2b_gap_busy", 32'(busy), 32'd0);
    check("b2b_gap_ready", 32'(s_ready), 32'd1);
    @(negedge clk);
    t2 = cyc;
    s_valid = 1'b0;
    check("b2b_period", 32'(t2 - t1), 32'd81);
    check_frame("b2b1", 20'b1_10000000_0_1_00000000_0, exp_bytes);
    exp_bytes = exp_bytes + 16'd2;
    @(negedge clk);
    check("b2b_cnt", 32'(bytes_sent), 32'd6);

    // Flow control: cts low holds off the offered sample
    cts     = 1'b0;
    s_valid = 1'b1;
    s_data  = 16'h1234;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("fc_ready", 32'(s_ready), 32'd0);
      check("fc_tx", 32'(tx), 32'd1);
    end
    cts = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    cts     = 1'b0;
    check("fc_start_tx", 32'(tx), 32'd0);
    check_frame("fc1234", 20'b1_00010010_0_1_00110100_0, exp_bytes);
    exp_bytes = exp_bytes + 16'd2;
    @(negedge clk);
    check("fc_end_busy", 32'(busy), 32'd0);
    check("fc_end_ready", 32'(s_ready), 32'd0);
    check("fc_end_cnt", 32'(bytes_sent), 32'(exp_bytes));
    cts = 1'b1;

    // Mid-frame reset during the high byte's data bits
    s_valid = 1'b1;
    s_data  = 16'h5555;
    wait_start("mfr", 10);
    s_valid = 1'b0;
    repeat (12 * BC + 2) @(negedge clk);
    check("mfr_pre_state", 32'(state_dbg), 32'(DATA));
    check("mfr_pre_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mfr_tx", 32'(tx), 32'd1);
    check("mfr_busy", 32'(busy), 32'd0);
    check("mfr_cnt", 32'(bytes_sent), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_bytes = 16'd0;
    check("mfr_ready", 32'(s_ready), 32'd1);
    s_valid = 1'b1;
    s_data  = 16'h00FF;
    @(negedge clk);
    s_valid = 1'b0;
    check("mfr_new_start", 32'(busy), 32'd1);
    check_frame("mfr00ff", 20'b1_00000000_0_1_11111111_0, exp_bytes);
    exp_bytes = exp_bytes + 16'd2;
    @(negedge clk);
    check("mfr_new_cnt", 32'(bytes_sent), 32'd2);

    // Counter wrap from 0xFFFE
    force dut.byte_count = 16'hFFFE;
    @(negedge clk);
    release dut.byte_count;
    @(negedge clk);
    check("wrap_preload", 32'(bytes_sent), 32'h0000_FFFE);
    exp_bytes = 16'hFFFE;
    s_valid = 1'b1;
    s_data  = 16'h0F0F;
    wait_start("wrap", 10);
    s_valid = 1'b0;
    check_frame("wrap0f0f", 20'b1_00001111_0_1_00001111_0, exp_bytes);
    @(negedge clk);
    check("wrap_cnt", 32'(bytes_sent), 32'd0);
    check("wrap_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
